// File: rtl/dense4_mac_layer.sv
// Four-neuron serial MAC bank: num_inputs beats, then shift/bias/saturate; results 2 edges after last beat.
// Backpressure: in_ready is high only while accumulating; in_valid gaps of any length just pause the sum.
module dense4_mac_layer #(
  parameter int input_width  = 8,
  parameter int weight_width = 8,
  parameter int num_inputs   = 16,
  parameter int acc_width    = 24,
  parameter int frac_shift   = 4,
  parameter int output_width = 12
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [input_width-1:0]   in_data,
  input  logic signed [weight_width-1:0]  w0,
  input  logic signed [weight_width-1:0]  w1,
  input  logic signed [weight_width-1:0]  w2,
  input  logic signed [weight_width-1:0]  w3,
  input  logic signed [output_width-1:0]  b0,
  input  logic signed [output_width-1:0]  b1,
  input  logic signed [output_width-1:0]  b2,
  input  logic signed [output_width-1:0]  b3,
  output logic signed [output_width-1:0]  out0,
  output logic signed [output_width-1:0]  out1,
  output logic signed [output_width-1:0]  out2,
  output logic signed [output_width-1:0]  out3,
  output logic                            output_ready,
  output logic                            busy
);

  localparam int cnt_width = $clog2(num_inputs + 1);
  localparam logic [cnt_width-1:0] last_beat = cnt_width'(num_inputs - 1);
  localparam logic signed [acc_width:0] sat_max =
    {{(acc_width + 2 - output_width){1'b0}}, {(output_width - 1){1'b1}}};
  localparam logic signed [acc_width:0] sat_min =
    {{(acc_width + 2 - output_width){1'b1}}, {(output_width - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL} state_t;

  state_t                         state;
  logic [cnt_width-1:0]           cnt;
  logic signed [acc_width-1:0]    acc  [4];
  logic signed [acc_width-1:0]    prod [4];
  logic signed [weight_width-1:0] w    [4];
  logic signed [output_width-1:0] b    [4];
  logic signed [output_width-1:0] res  [4];

  assign w[0] = w0;
  assign w[1] = w1;
  assign w[2] = w2;
  assign w[3] = w3;
  assign b[0] = b0;
  assign b[1] = b1;
  assign b[2] = b2;
  assign b[3] = b3;

  function automatic logic signed [acc_width-1:0] mul(
    input logic signed [input_width-1:0]  a,
    input logic signed [weight_width-1:0] c
  );
    logic signed [acc_width-1:0] ae;
    logic signed [acc_width-1:0] ce;
    ae = {{(acc_width - input_width){a[input_width-1]}}, a};
    ce = {{(acc_width - weight_width){c[weight_width-1]}}, c};
    return ae * ce;
  endfunction

  // One extra bit of headroom makes the bias add exact before clamping.
  function automatic logic signed [output_width-1:0] scale(
    input logic signed [acc_width-1:0]    a,
    input logic signed [output_width-1:0] bias
  );
    logic signed [acc_width-1:0] sh;
    logic signed [acc_width:0]   sum;
    sh  = a >>> frac_shift;
    sum = {sh[acc_width-1], sh} + {{(acc_width + 1 - output_width){bias[output_width-1]}}, bias};
    if (sum > sat_max)      return {1'b0, {(output_width - 1){1'b1}}};
    else if (sum < sat_min) return {1'b1, {(output_width - 1){1'b0}}};
    else                    return sum[output_width-1:0];
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      prod[k] = mul(in_data, w[k]);
      res[k]  = scale(acc[k], b[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      for (int k = 0; k < 4; k++) acc[k] <= '0;
      out0         <= '0;
      out1         <= '0;
      out2         <= '0;
      out3         <= '0;
      output_ready <= 1'b0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      output_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            cnt      <= '0;
            for (int k = 0; k < 4; k++) acc[k] <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (in_valid && in_ready) begin
            for (int k = 0; k < 4; k++) acc[k] <= acc[k] + prod[k];
            cnt <= cnt + cnt_width'(1);
            if (cnt == last_beat) begin
              state    <= FINAL;
              in_ready <= 1'b0;
            end
          end
        end
        FINAL: begin
          out0         <= res[0];
          out1         <= res[1];
          out2         <= res[2];
          out3         <= res[3];
          output_ready <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense4_mac_layer.sv
// Bench for dense4_mac_layer: directed table, stall/abort/back-to-back sequences, randomized ops vs model.
module tb_dense4_mac_layer;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] in_data = '0;
  logic signed [7:0] w0 = '0, w1 = '0, w2 = '0, w3 = '0;
  logic signed [11:0] b0 = '0, b1 = '0, b2 = '0, b3 = '0;
  logic signed [11:0] out0, out1, out2, out3;
  logic              output_ready;
  logic              busy;

  dense4_mac_layer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .output_ready(output_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       d;
    logic [3:0][7:0]  w;
    logic [3:0][11:0] b;
    logic             single;
    logic [3:0][11:0] e;
  } vec_t;

  int     checks = 0;
  int     failures = 0;
  int     beat_d [16];
  int     beat_w [4][16];
  int     bias [4];
  int     exp_out [4];
  int     prev_out [4];
  vec_t   tbl [5];

  task automatic chk(input string name, input integer act, input integer req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic integer outk(input int k);
    case (k)
      0:       return {{20{out0[11]}}, out0};
      1:       return {{20{out1[11]}}, out1};
      2:       return {{20{out2[11]}}, out2};
      default: return {{20{out3[11]}}, out3};
    endcase
  endfunction

  // Reference: exact dot product, floor division by 2^4, bias, clamp to 12-bit signed.
  function automatic int model(input int k);
    longint s = 0;
    longint q;
    for (int i = 0; i < 16; i++) s += longint'(beat_d[i]) * longint'(beat_w[k][i]);
    q = s / 16;
    if (s < 0 && q * 16 != s) q -= 1;
    q += bias[k];
    if (q > 2047) q = 2047;
    if (q < -2048) q = -2048;
    return int'(q);
  endfunction

  function automatic int s8(input logic [7:0] x);
    return int'($signed(x));
  endfunction

  function automatic int s12(input logic [11:0] x);
    return int'($signed(x));
  endfunction

  function automatic vec_t mk(input int d, input int x0, input int x1, input int x2, input int x3,
                              input int c0, input int c1, input int c2, input int c3, input bit single,
                              input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.d = 8'(d);
    v.w[0] = 8'(x0); v.w[1] = 8'(x1); v.w[2] = 8'(x2); v.w[3] = 8'(x3);
    v.b[0] = 12'(c0); v.b[1] = 12'(c1); v.b[2] = 12'(c2); v.b[3] = 12'(c3);
    v.single = single;
    v.e[0] = 12'(e0); v.e[1] = 12'(e1); v.e[2] = 12'(e2); v.e[3] = 12'(e3);
    return v;
  endfunction

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 16; i++) begin
      beat_d[i] = (v.single && i > 0) ? 0 : s8(v.d);
      for (int k = 0; k < 4; k++) beat_w[k][i] = (v.single && i > 0) ? 0 : s8(v.w[k]);
    end
    for (int k = 0; k < 4; k++) begin
      bias[k]    = s12(v.b[k]);
      exp_out[k] = s12(v.e[k]);
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < 16; i++) begin
      beat_d[i] = int'($urandom_range(255, 0)) - 128;
      for (int k = 0; k < 4; k++) beat_w[k][i] = int'($urandom_range(255, 0)) - 128;
    end
    for (int k = 0; k < 4; k++) begin
      bias[k]    = int'($urandom_range(4095, 0)) - 2048;
      exp_out[k] = model(k);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the output_ready cycle so a caller may chain a start.
  task automatic run_op(input int max_gap, input bit poke);
    int n;
    int gap;
    start = 1'b1; in_valid = 1'b1; in_data = 8'sd99;
    w0 = 8'sd7; w1 = 8'sd7; w2 = 8'sd7; w3 = 8'sd7;
    cyc();
    start = 1'b0; in_valid = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    b0 = 12'sd1000; b1 = -12'sd1000; b2 = 12'sd333; b3 = -12'sd77;
    for (int i = 0; i < 16; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        start = poke;
        cyc();
      end
      start    = 1'b0;
      in_data  = 8'(beat_d[i]);
      w0 = 8'(beat_w[0][i]); w1 = 8'(beat_w[1][i]); w2 = 8'(beat_w[2][i]); w3 = 8'(beat_w[3][i]);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 8) begin
        in_valid = 1'b0;
        cyc();
        n++;
        in_valid = 1'b1;
      end
      chk("in_ready_during_accum", 32'(in_ready), 1);
      cyc();
      in_valid = 1'b0;
    end
    b0 = 12'(bias[0]); b1 = 12'(bias[1]); b2 = 12'(bias[2]); b3 = 12'(bias[3]);
    chk("in_ready_in_final", 32'(in_ready), 0);
    chk("no_early_pulse", 32'(output_ready), 0);
    for (int k = 0; k < 4; k++) chk($sformatf("hold_out%0d", k), outk(k), prev_out[k]);
    cyc();
    chk("pulse_high", 32'(output_ready), 1);
    chk("busy_low_after", 32'(busy), 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out%0d", k), outk(k), exp_out[k]);
      prev_out[k] = exp_out[k];
    end
  endtask

  task automatic end_pulse();
    cyc();
    chk("pulse_one_cycle", 32'(output_ready), 0);
    for (int k = 0; k < 4; k++) chk($sformatf("held_out%0d", k), outk(k), prev_out[k]);
  endtask

  initial begin
    int pulses;
    tbl[0] = mk(16, 16, 16, 16, 16, 0, 0, 0, 0, 1'b0, 256, 256, 256, 256);
    tbl[1] = mk(127, 127, -128, 0, 1, 0, 0, 0, 0, 1'b0, 2047, -2048, 0, 127);
    tbl[2] = mk(-1, 0, 0, 1, 0, 0, 0, 5, -3, 1'b1, 0, 0, 4, -3);
    tbl[3] = mk(-128, -128, 127, -1, 3, -2048, 2047, 100, -100, 1'b0, 2047, -2048, 228, -484);
    tbl[4] = mk(-17, 1, -1, 17, 0, 0, 0, 0, 7, 1'b1, -2, 1, -19, 7);
    for (int k = 0; k < 4; k++) prev_out[k] = 0;

    #3;
    for (int k = 0; k < 4; k++) chk($sformatf("reset_out%0d", k), outk(k), 0);
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_output_ready", 32'(output_ready), 0);
    #9 rst_n = 1'b1;
    cyc();

    // Beats offered while idle must not be counted.
    in_valid = 1'b1; in_data = 8'sd100; w0 = 8'sd100; w1 = 8'sd100; w2 = 8'sd100; w3 = 8'sd100;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_in_ready", 32'(in_ready), 0);
      chk("idle_busy", 32'(busy), 0);
    end
    in_valid = 1'b0;

    for (int r = 0; r < 5; r++) begin
      load_vec(tbl[r]);
      run_op(0, 1'b0);
      end_pulse();
    end

    // Same vector with random stalls and start pokes must give the same answer.
    load_vec(tbl[3]);
    run_op(5, 1'b1);
    end_pulse();

    // Abort after 7 beats.
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 8'sd50; w0 = 8'sd50; w1 = -8'sd50; w2 = 8'sd50; w3 = 8'sd50;
      cyc();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) chk($sformatf("abort_out%0d", k), outk(k), 0);
    chk("abort_in_ready", 32'(in_ready), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_output_ready", 32'(output_ready), 0);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) prev_out[k] = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (output_ready) pulses++;
    end
    chk("no_pulse_after_abort", pulses, 0);
    load_random();
    run_op(0, 1'b0);
    end_pulse();

    // Back-to-back: second start lands in the pulse cycle.
    load_vec(tbl[0]);
    run_op(0, 1'b0);
    load_vec(tbl[1]);
    run_op(0, 1'b0);
    end_pulse();

    for (int r = 0; r < 12; r++) begin
      load_random();
      run_op(int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
      if (r % 2 == 1) end_pulse();
    end
    end_pulse();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dense4_mac_layer.md
Name: dense4_mac_layer

Overview:
- Hidden-layer neuron bank sitting directly upstream of the 4-lane ReLU stage.
- Computes four parallel dot products over a serial stream of num_inputs activations, each with its own per-beat weight.
- After the last beat, each result is scaled by an arithmetic right shift, biased, and saturated.
- Drives out0..out3 plus a one-cycle output_ready pulse, which connects to the ReLU input_ready.

Parameters:
- input_width, 8, signed activation width
- weight_width, 8, signed weight width
- num_inputs, 16, beats per dot product (>=2)
- acc_width, 24, accumulator width; must be >= input_width+weight_width+clog2(num_inputs)
- frac_shift, 4, arithmetic right shift applied to the accumulator before bias
- output_width, 12, signed output and bias width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous assert, active-low
- start  in  1  begin new dot product (honoured only in IDLE)
- in_valid  in  1  activation/weight beat valid
- in_ready  out  1  high only in ACCUM; a beat transfers when in_valid & in_ready
- in_data  in  input_width  signed activation
- w0..w3  in  weight_width each  signed weight for neuron 0..3, sampled with the beat
- b0..b3  in  output_width each  signed bias, sampled in FINAL
- out0..out3  out  output_width each  signed result, held until next result
- output_ready  out  1  one-cycle pulse, results valid
- busy  out  1  high in ACCUM or FINAL

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; accumulators, beat counter, out0..out3, output_ready, in_ready and busy are all 0.
- Reset asserted mid-operation aborts the operation. Partial sums are discarded and no output_ready is produced.
- FSM states are IDLE, ACCUM and FINAL.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start=1 clears the accumulators and the counter, then moves to ACCUM on the next edge.
  - A start coincident with in_valid does not transfer that beat.
- ACCUM:
  - On each transfer, acc_k += sext(in_data) * sext(w_k) at full signed precision, for k=0..3, and the counter increments.
  - in_valid=0 holds all state; gaps of any length are legal.
  - The transfer that brings the count to num_inputs moves to FINAL, and in_ready drops the next cycle.
  - start is ignored.
- FINAL (exactly one cycle):
  - r_k = (acc_k >>> frac_shift), an arithmetic shift that floors toward -inf.
  - Then r_k + sext(b_k), computed without overflow.
  - Then saturate to [-2^(output_width-1), 2^(output_width-1)-1].
  - The result is registered into out_k, output_ready is set to 1, and the state returns to IDLE.
- output_ready:
  - Asserted for exactly one cycle, visible in the cycle after FINAL, i.e. 2 edges after the last transfer edge.
  - Deasserted on the following edge.
- Latency: last beat transfer edge -> outputs and output_ready valid 2 edges later.
- Minimum period between results is num_inputs+2 cycles, given start asserted in the pulse cycle.
- A start in the output_ready cycle (state is IDLE) is honoured; the outputs still hold their values until the next FINAL.
- out0..out3 change only on a FINAL edge or reset.
- No internal overflow is possible: the acc_width constraint guarantees it. Saturation applies only at the output.

Test Plan:
- Reset, then start, then 16 beats with in_data=16, w0..w3=16, b=0 -> out0..3=256; output_ready a single pulse exactly 2 edges after the 16th transfer.
- Saturation: in_data=127, w0=127, w1=-128, b=0 -> out0=2047 (acc 258064 >>4 = 16129); out1=-2048 (acc -260096 >>4 = -16256).
- Floor and bias: one beat with in_data=-1, w2=1, all other beats 0, b2=5 -> out2=4 (-1>>>4=-1, +5); b3=-3 with zero products -> out3=-3.
- Stalls and ignored controls:
  - Random in_valid gaps of 0-5 cycles give results identical to the no-stall run.
  - start pulsed during ACCUM has no effect.
  - in_valid in IDLE does not count as a beat.
- Reset mid-ACCUM after 7 beats -> all outputs 0, in_ready=0, no output_ready pulse. A new start then 16 beats produces a correct, uncontaminated result.
- Back-to-back: start asserted in the output_ready cycle -> second result correct, and out0..3 hold the first result until the second pulse.
